mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/memarb_pkg.sv | 30 +++
 rtl/mem_arbiter_rr_picker.sv | 37 +++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/memarb_pkg.sv
// Shared types and defaults for the cache-to-memory arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package memarb_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Kind of memory access latched at grant time.
  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_t;

  // Default parameter values.
  localparam int MEMARB_NCH     = 2;
  localparam int MEMARB_AW      = 32;
  localparam int MEMARB_DW      = 32;
  localparam int MEMARB_TIMEOUT = 64;

  // Width of a channel id. It is kept at one bit for a single channel so the
  // grant_id port never collapses to zero width.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin picker: first set request bit strictly after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld low when no request bit is set.
//
// Ports: req  - request vector, one bit per channel
//        ptr  - last granted channel; the search starts at ptr+1
//        id   - selected channel (0 when vld is low)
//        vld  - at least one request present
module rr_picker
  import memarb_pkg::*;
#(
  parameter int NCH = MEMARB_NCH,
  parameter int GW  = id_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [GW-1:0]  ptr,
  output logic [GW-1:0]  id,
  output logic           vld
);

  logic [2*NCH-1:0] dbl;

  always_comb begin
    // Rotate so that bit 0 is channel ptr+1; the doubled copy handles the
    // wrap, and a shift by NCH (ptr = NCH-1) just returns req unrotated.
    dbl = {req, req} >> (int'(ptr) + 1);
    id  = '0;
    vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!vld && dbl[i]) begin
        vld = 1'b1;
        id  = GW'((int'(ptr) + 1 + i) % NCH);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NCH cache channels one shared memory port.
// Latency: grant edge then ack cycle (2 cycles min); one IDLE cycle between accesses.
// Backpressure: requests held until req_wait drops; ACCESS holds until mem_ack.
//
// Ports: CLK/RST (sync, active-high); req_ren/req_wen/req_addr/req_wdata per
//        channel in; req_wait per channel and req_load (broadcast read data)
//        out; mem_ren/mem_wen/mem_addr/mem_wdata to memory, mem_rdata/mem_ack
//        from memory; grant_id, busy, timeout_err status.
// Optional feature: define MEMARB_WATCHDOG_EN to abort accesses that see no
// mem_ack within TIMEOUT cycles (timeout_err pulses, channel stays waiting).
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter  int NCH     = MEMARB_NCH,
  parameter  int AW      = MEMARB_AW,
  parameter  int DW      = MEMARB_DW,
  parameter  int TIMEOUT = MEMARB_TIMEOUT,
  localparam int GW      = id_w(NCH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NCH-1:0]          req_ren,
  input  logic [NCH-1:0]          req_wen,
  input  logic [NCH-1:0][AW-1:0]  req_addr,
  input  logic [NCH-1:0][DW-1:0]  req_wdata,
  output logic [NCH-1:0]          req_wait,
  output logic [DW-1:0]           req_load,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  input  logic [DW-1:0]           mem_rdata,
  input  logic                    mem_ack,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  state_t          state, state_nxt;
  logic [NCH-1:0]  req_any;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   gnt_id;
  logic [GW-1:0]   pick_id;
  logic            pick_vld;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  acc_t            lat_acc;
  logic            grant;
  logic            done;
  logic            wd_expire;

  assign req_any = req_ren | req_wen;

  rr_picker #(
    .NCH (NCH),
    .GW  (GW)
  ) u_pick (
    .req (req_any),
    .ptr (last_grant),
    .id  (pick_id),
    .vld (pick_vld)
  );

`ifdef MEMARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          tmo_q;

  // wd_cnt holds the number of completed ACCESS cycles, so the TIMEOUT-th
  // ACCESS cycle without an ack is the one that aborts.
  assign wd_expire = (state == ACCESS) && !mem_ack && (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= wd_expire;
      if ((state == ACCESS) && !mem_ack && !wd_expire) begin
        wd_cnt <= wd_cnt + CW'(1);
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  assign timeout_err = tmo_q;
`else
  assign wd_expire   = 1'b0;
  // Constant 0 for every legal TIMEOUT; ACCESS simply waits for mem_ack.
  assign timeout_err = (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-channel wait.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    req_wait  = '1;
    case (state)
      IDLE: begin
        // mem_ack is deliberately ignored here.
        if (pick_vld) begin
          state_nxt = ACCESS;
          grant     = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_nxt = IDLE;
          done      = 1'b1;
          // A requester that has already withdrawn is not told it completed.
          req_wait[gnt_id] = !req_any[gnt_id];
        end else if (wd_expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch and round-robin pointer. The pointer also advances on a
  // watchdog abort so the stalled channel goes to the back of the queue.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant <= GW'(NCH - 1);
      gnt_id     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_acc    <= ACC_READ;
    end else begin
      if (grant) begin
        gnt_id    <= pick_id;
        lat_addr  <= req_addr[pick_id];
        lat_wdata <= req_wdata[pick_id];
        // ren and wen together count as a write.
        lat_acc   <= req_wen[pick_id] ? ACC_WRITE : ACC_READ;
      end
      if (done || wd_expire) begin
        last_grant <= gnt_id;
      end
    end
  end

  assign busy      = (state == ACCESS);
  assign mem_ren   = busy && (lat_acc == ACC_READ);
  assign mem_wen   = busy && (lat_acc == ACC_WRITE);
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign grant_id  = gnt_id;
  assign req_load  = mem_rdata;

endmodule
